// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the display scan controller and its
// seven-segment decoder.
//   state_e  : scan FSM states (IDLE, BLANK, DRIVE)
//   SEG_W    : width of a segment pattern
//   NIBBLE_W : width of one display digit in the display word
//   SEG_DARK : all segments off
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;
  localparam logic [SEG_W-1:0] SEG_DARK = 7'b0000000;

endpackage

// File: rtl/sevenseg.sv
// -----------------------------------------------------------------------------
// sevenseg
// Combinational hex-nibble to seven-segment decoder. Segment bit order is
// {a, f, b, g, e, c, d} (bit 6 down to bit 0). Nibbles 10..15 all show the
// error glyph "E".
//   i_nibble : digit value to display
//   o_seg    : segment pattern, 1 = segment lit
// -----------------------------------------------------------------------------
module sevenseg
  import display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [SEG_W-1:0]    o_seg
);

  // Glyph lookup table
  always_comb begin
    case (i_nibble)
      4'h0:    o_seg = 7'b1110111;
      4'h1:    o_seg = 7'b0010010;
      4'h2:    o_seg = 7'b1011101;
      4'h3:    o_seg = 7'b1011011;
      4'h4:    o_seg = 7'b0111010;
      4'h5:    o_seg = 7'b1101011;
      4'h6:    o_seg = 7'b1101111;
      4'h7:    o_seg = 7'b1010010;
      4'h8:    o_seg = 7'b1111111;
      4'h9:    o_seg = 7'b1111011;
      default: o_seg = 7'b1101101;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS common-segment 7-segment
// display. Each digit gets BLANK_CYCLES dark cycles followed by DWELL_CYCLES
// driven cycles. New words arrive through a valid/ready handshake into a
// pending buffer and are committed only at the start of digit 0, so a frame
// never mixes two words.
//   clk, n_reset : clock, asynchronous active-low reset
//   enable       : scanning enabled; low forces dark outputs
//   lz_suppress  : blank leading zero digits (sampled as each digit starts)
//   load_valid   : host presents load_data
//   load_data    : display word, nibble k = digit k
//   load_ready   : pending buffer empty, a word can be accepted
//   seg          : registered segment pattern
//   digit_en     : registered one-hot digit enable, zero when dark
//   frame_done   : one-cycle pulse after the last digit's dwell ends
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic                           enable,
  input  logic                           lz_suppress,
  input  logic                           load_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
  output logic                           load_ready,
  output logic [SEG_W-1:0]               seg,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           frame_done
);

  localparam int WORD_W  = NIBBLE_W * NUM_DIGITS;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DEN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  r_state;
  logic [WORD_W-1:0]       r_active;
  logic [WORD_W-1:0]       r_pending;
  logic                    r_pending_full;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [SEG_W-1:0]        r_seg;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_done;

  state_e                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [SEG_W-1:0]        w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_digit_en_nxt;
  logic                    w_frame_done_nxt;
  logic                    w_commit;
  logic [WORD_W-1:0]       w_word;
  logic [NIBBLE_W-1:0]     w_nibble;
  logic                    w_upper_nonzero;
  logic                    w_suppress;
  logic [SEG_W-1:0]        w_dec_seg;
  logic [SEG_W-1:0]        w_seg_sel;

  // Digit 0 decodes the word being committed on the same edge, so the first
  // digit of a frame already shows the new word.
  assign w_word     = ((r_idx == '0) && r_pending_full) ? r_pending : r_active;
  assign load_ready = !r_pending_full;

  // Nibble select and leading-zero detection for the current digit
  always_comb begin
    w_nibble        = '0;
    w_upper_nonzero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nibble = (IDX_W'(k) == r_idx) ? w_word[k*NIBBLE_W +: NIBBLE_W] : w_nibble;
      w_upper_nonzero = w_upper_nonzero |
                        ((IDX_W'(k) >= r_idx) && (w_word[k*NIBBLE_W +: NIBBLE_W] != 4'd0));
    end
    w_suppress = lz_suppress && (r_idx != '0) && !w_upper_nonzero;
    w_seg_sel  = w_suppress ? SEG_DARK : w_dec_seg;
  end

  sevenseg u_sevenseg (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // Next-state, counters and next output values
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_seg_nxt        = SEG_DARK;
    w_digit_en_nxt   = '0;
    w_frame_done_nxt = 1'b0;
    w_commit         = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt    = DRIVE;
            w_cnt_nxt      = '0;
            w_commit       = (r_idx == '0) && r_pending_full;
            w_seg_nxt      = w_seg_sel;
            w_digit_en_nxt = DEN_ONE << r_idx;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt        = '0;
              w_frame_done_nxt = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt      = r_cnt + CNT_W'(1);
            w_seg_nxt      = r_seg;
            w_digit_en_nxt = r_digit_en;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan counters, registered outputs and the double-buffered word
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_idx          <= '0;
      r_cnt          <= '0;
      r_seg          <= SEG_DARK;
      r_digit_en     <= '0;
      r_frame_done   <= 1'b0;
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_seg        <= w_seg_nxt;
      r_digit_en   <= w_digit_en_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_commit) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
      end else if (load_valid && !r_pending_full) begin
        r_pending      <= load_data;
        r_pending_full <= 1'b1;
      end else begin
        r_pending_full <= r_pending_full;
      end
    end
  end

  assign seg        = r_seg;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

endmodule
